// File: rtl/chip_spreader.sv
// rtl/chip_spreader.sv - 802.15.4 DSSS spreader: byte FIFO, nibble split, 32-chip PN serialiser
module chip_spreader #(
  parameter int CLK_DIV    = 25,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  input  logic       coder_ready,
  output logic       b_out,
  output logic       en_2MHz,
  output logic       mem_state,
  output logic       underrun
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE = DW'(1);
  localparam logic [31:0]   SYM0    = 32'b1101_1001_1100_0011_0101_0010_0010_1110;

  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

  state_t        state_q, state_d;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [DW-1:0] div_cnt_q, div_cnt_d;
  logic [4:0]    chip_idx_q, chip_idx_d;
  logic [3:0]    sym_q, sym_d, hi_nib_q, hi_nib_d;
  logic          hi_pending_q, hi_pending_d;
  logic          b_out_q, b_out_d, en_q, en_d;
  logic          mem_state_q, mem_state_d, underrun_q, underrun_d;
  logic          push, pop, fifo_empty, fifo_full, tick, emit, last_chip;
  logic [7:0]    head;
  logic [3:0]    cur_sym;
  logic [4:0]    cur_idx;
  logic [31:0]   cur_row;

  // Row is MSB-first (c0 at bit 31); a right chip shift is a rotate right of the word.
  function automatic logic [31:0] chip_row(input logic [3:0] s);
    logic [63:0] dbl;
    logic [31:0] rot;
    dbl = {SYM0, SYM0};
    rot = dbl[{s[2:0], 2'b00} +: 32];
    return s[3] ? (rot ^ 32'h5555_5555) : rot;
  endfunction

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == DEPTH_C);
  assign byte_ready = resetn & ~fifo_full;
  assign push       = byte_valid & byte_ready;
  assign head       = mem_q[rd_ptr_q];

  // LOAD doubles as the div_cnt==0 slot of the first chip so the strobe lands two cycles after the push.
  assign tick      = (state_q == LOAD) || ((state_q == SEND) && (div_cnt_q == '0));
  assign emit      = tick & coder_ready;
  assign cur_sym   = (state_q == LOAD) ? head[3:0] : sym_q;
  assign cur_idx   = (state_q == LOAD) ? 5'd0 : chip_idx_q;
  assign cur_row   = chip_row(cur_sym);
  assign last_chip = emit && (state_q == SEND) && (chip_idx_q == 5'd31);

  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    chip_idx_d   = chip_idx_q;
    sym_d        = sym_q;
    hi_nib_d     = hi_nib_q;
    hi_pending_d = hi_pending_q;
    b_out_d      = b_out_q;
    en_d         = 1'b0;
    underrun_d   = underrun_q;
    pop          = 1'b0;
    if (emit) begin
      b_out_d    = cur_row[5'd31 - cur_idx];
      en_d       = 1'b1;
      chip_idx_d = cur_idx + 5'd1;
    end
    case (state_q)
      IDLE: begin
        div_cnt_d  = '0;
        chip_idx_d = '0;
        if (!fifo_empty || push) state_d = LOAD;
      end
      LOAD: begin
        pop          = 1'b1;
        sym_d        = head[3:0];
        hi_nib_d     = head[7:4];
        hi_pending_d = 1'b1;
        div_cnt_d    = DIV_ONE;
        if (!emit) chip_idx_d = '0;
        state_d      = SEND;
      end
      SEND: begin
        div_cnt_d = (div_cnt_q == DIV_MAX) ? '0 : div_cnt_q + DIV_ONE;
        if (last_chip) begin
          if (hi_pending_q) begin
            sym_d        = hi_nib_q;
            hi_pending_d = 1'b0;
          end else if (!fifo_empty) begin
            pop          = 1'b1;
            sym_d        = head[3:0];
            hi_nib_d     = head[7:4];
            hi_pending_d = 1'b1;
          end else begin
            state_d    = IDLE;
            underrun_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    mem_state_d = (state_d == SEND);
    wr_ptr_d    = wr_ptr_q + AW'(push);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    count_d     = count_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      div_cnt_q    <= '0;
      chip_idx_q   <= '0;
      sym_q        <= '0;
      hi_nib_q     <= '0;
      hi_pending_q <= 1'b0;
      b_out_q      <= 1'b0;
      en_q         <= 1'b0;
      mem_state_q  <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      div_cnt_q    <= div_cnt_d;
      chip_idx_q   <= chip_idx_d;
      sym_q        <= sym_d;
      hi_nib_q     <= hi_nib_d;
      hi_pending_q <= hi_pending_d;
      b_out_q      <= b_out_d;
      en_q         <= en_d;
      mem_state_q  <= mem_state_d;
      underrun_q   <= underrun_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= byte_in;
  end

  assign b_out     = b_out_q;
  assign en_2MHz   = en_q;
  assign mem_state = mem_state_q;
  assign underrun  = underrun_q;

endmodule
